// File: rtl/result_uart_tx_if.sv
// Bundles the result-request side and the UART byte side of result_uart_tx.
// The slave modport belongs to the transmitter; master belongs to whoever drives it.
interface result_uart_tx_if;
  logic [8:0] result;
  logic       o_flag;
  logic       result_ready;
  logic       txready;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       drop;

  modport slave (
    input  result, o_flag, result_ready, txready,
    output txdata, txclk, busy, drop
  );

  modport master (
    output result, o_flag, result_ready, txready,
    input  txdata, txclk, busy, drop
  );
endinterface

// File: rtl/result_uart_tx.sv
// Converts a finished 9-bit signed calculator result to ASCII decimal and
// streams it out one byte per transfer on the txdata/txclk/txready port.
//
// state | meaning
// IDLE  | waiting for result_ready; busy=0
// CONV  | repeated subtraction of 100s then 10s, one step per cycle
// LOAD  | assemble byte buffer and length, present first byte
// SEND  | offer buffer[idx] with txclk=1 until the last byte transfers
module result_uart_tx #(
  parameter bit NEWLINE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               nrst,
  result_uart_tx_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD, SEND} state_t;

  state_t     state_q, state_d;
  logic [8:0] mag_q, mag_d;
  logic       neg_q, neg_d;
  logic       ovf_q, ovf_d;
  logic [1:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [7:0] byte_buf_q [6];
  logic [7:0] byte_buf_d [6];
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] txdata_q, txdata_d;
  logic       txclk_q, txclk_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;
  logic [2:0] pos;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      hund_q   <= '0;
      tens_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < 6; i++) byte_buf_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      for (int i = 0; i < 6; i++) byte_buf_q[i] <= byte_buf_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    len_d    = len_q;
    idx_d    = idx_q;
    txdata_d = txdata_q;
    txclk_d  = txclk_q;
    busy_d   = busy_q;
    pos      = 3'd0;
    for (int i = 0; i < 6; i++) byte_buf_d[i] = byte_buf_q[i];
    // Any request seen while a frame is in flight, including its last cycle, is refused.
    drop_d   = bus.result_ready & busy_q;

    case (state_q)
      IDLE: begin
        if (bus.result_ready) begin
          busy_d  = 1'b1;
          ovf_d   = bus.o_flag;
          neg_d   = bus.result[8];
          mag_d   = bus.result[8] ? (~bus.result + 9'd1) : bus.result;
          hund_d  = 2'd0;
          tens_d  = 4'd0;
          state_d = bus.o_flag ? LOAD : CONV;
        end
      end

      CONV: begin
        if (mag_q >= 9'd100) begin
          mag_d  = mag_q - 9'd100;
          hund_d = hund_q + 2'd1;
        end else if (mag_q >= 9'd10) begin
          mag_d  = mag_q - 9'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (ovf_q) begin
          byte_buf_d[0] = 8'h45;
          byte_buf_d[1] = 8'h52;
          byte_buf_d[2] = 8'h52;
          pos = 3'd3;
        end else begin
          if (neg_q) begin
            byte_buf_d[pos] = 8'h2D;
            pos = pos + 3'd1;
          end
          if (hund_q != 2'd0) begin
            byte_buf_d[pos] = 8'h30 + {6'd0, hund_q};
            pos = pos + 3'd1;
          end
          if (hund_q != 2'd0 || tens_q != 4'd0) begin
            byte_buf_d[pos] = 8'h30 + {4'd0, tens_q};
            pos = pos + 3'd1;
          end
          byte_buf_d[pos] = 8'h30 + {4'd0, mag_q[3:0]};
          pos = pos + 3'd1;
        end
        if (NEWLINE_EN) begin
          byte_buf_d[pos]        = 8'h0D;
          byte_buf_d[pos + 3'd1] = 8'h0A;
          pos = pos + 3'd2;
        end
        len_d    = pos;
        idx_d    = 3'd0;
        txdata_d = byte_buf_d[0];
        txclk_d  = 1'b1;
        state_d  = SEND;
      end

      SEND: begin
        if (bus.txready) begin
          if (idx_q == len_q - 3'd1) begin
            txclk_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d    = idx_q + 3'd1;
            txdata_d = byte_buf_q[idx_q + 3'd1];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.txdata = txdata_q;
  assign bus.txclk  = txclk_q;
  assign bus.busy   = busy_q;
  assign bus.drop   = drop_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: an ASCII model fills per-DUT expected-byte
// queues at request time; negedge monitors pop and compare each transferred byte.
module tb_result_uart_tx;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  result_uart_tx_if ifc0 ();
  result_uart_tx_if ifc1 ();

  result_uart_tx #(.NEWLINE_EN(1'b1)) dut0 (.clk(clk), .nrst(nrst), .bus(ifc0));
  result_uart_tx #(.NEWLINE_EN(1'b0)) dut1 (.clk(clk), .nrst(nrst), .bus(ifc1));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] e0, e1;
  int txc0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference ASCII encoder built from integer arithmetic.
  task automatic push_exp(input logic [8:0] res, input logic of, input bit nl,
                          input bit sel, output int n);
    logic [7:0] q[$];
    int v;
    if (of) begin
      q.push_back(8'h45); q.push_back(8'h52); q.push_back(8'h52);
    end else begin
      v = int'($signed(res));
      if (v < 0) begin q.push_back(8'h2D); v = -v; end
      if (v >= 100) q.push_back(8'(8'h30 + v / 100));
      if (v >= 10)  q.push_back(8'(8'h30 + (v / 10) % 10));
      q.push_back(8'(8'h30 + v % 10));
    end
    if (nl) begin q.push_back(8'h0D); q.push_back(8'h0A); end
    n = q.size();
    foreach (q[i]) begin
      if (sel) exp1_q.push_back(q[i]);
      else     exp0_q.push_back(q[i]);
    end
  endtask

  always @(negedge clk) begin
    if (nrst && ifc0.txclk) begin
      txc0++;
      chk("txclk_implies_busy0", {31'd0, ifc0.busy}, 32'd1);
      if (ifc0.txready) begin
        e0 = (exp0_q.size() != 0) ? exp0_q.pop_front() : 8'hxx;
        chk("byte0", {24'd0, ifc0.txdata}, {24'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && ifc1.txclk && ifc1.txready) begin
      e1 = (exp1_q.size() != 0) ? exp1_q.pop_front() : 8'hxx;
      chk("byte1", {24'd0, ifc1.txdata}, {24'd0, e1});
    end
  end

  task automatic request0(input logic [8:0] res, input logic of, input int hold, output int n);
    @(posedge clk); #1;
    ifc0.result = res;
    ifc0.o_flag = of;
    ifc0.result_ready = 1'b1;
    push_exp(res, of, 1'b1, 1'b0, n);
    txc0 = 0;
    repeat (hold) @(posedge clk);
    #1;
    ifc0.result_ready = 1'b0;
    ifc0.result = 9'($urandom);
    ifc0.o_flag = 1'b0;
    if (hold == 2) begin
      @(negedge clk);
      chk("drop_back_to_back", {31'd0, ifc0.drop}, 32'd1);
    end
  endtask

  task automatic wait_done0(input string tag, input int nbytes, input bit b2b);
    bit done = 1'b0;
    int i = 0;
    while (!done && i < 300) begin
      @(negedge clk);
      if (!ifc0.busy) done = 1'b1;
      i++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_txclk_low"}, {31'd0, ifc0.txclk}, 32'd0);
    chk({tag, "_queue_empty"}, exp0_q.size(), 32'd0);
    if (b2b) chk({tag, "_b2b"}, txc0, nbytes);
  endtask

  task automatic wait_txclk0(input string tag);
    bit seen = 1'b0;
    int i = 0;
    while (!seen && i < 100) begin
      @(negedge clk);
      if (ifc0.txclk) seen = 1'b1;
      i++;
    end
    chk({tag, "_txclk_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int n;
    ifc0.result = '0; ifc0.o_flag = 1'b0; ifc0.result_ready = 1'b0; ifc0.txready = 1'b1;
    ifc1.result = '0; ifc1.o_flag = 1'b0; ifc1.result_ready = 1'b0; ifc1.txready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_txdata", {24'd0, ifc0.txdata}, 32'h00);
    chk("rst_txclk",  {31'd0, ifc0.txclk}, 32'd0);
    chk("rst_busy",   {31'd0, ifc0.busy}, 32'd0);
    chk("rst_drop",   {31'd0, ifc0.drop}, 32'd0);
    nrst = 1'b1;

    request0(9'd123, 1'b0, 1, n);
    wait_done0("r123", n, 1'b1);
    request0(9'h100, 1'b0, 1, n);
    wait_done0("rneg256", n, 1'b1);
    request0(9'h1F9, 1'b0, 2, n);
    wait_done0("rneg7", n, 1'b1);
    request0(9'd0, 1'b0, 1, n);
    wait_done0("r0", n, 1'b1);
    request0(9'd77, 1'b1, 1, n);
    wait_done0("rerr", n, 1'b1);

    // Backpressure: let one byte go, then stall for 5 cycles.
    ifc0.txready = 1'b0;
    request0(9'd105, 1'b0, 1, n);
    wait_txclk0("bp");
    @(posedge clk); #1; ifc0.txready = 1'b1;
    @(posedge clk); #1; ifc0.txready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_txclk_hold", {31'd0, ifc0.txclk}, 32'd1);
      chk("bp_txdata_hold", {24'd0, ifc0.txdata}, {24'd0, exp0_q[0]});
    end
    @(posedge clk); #1; ifc0.txready = 1'b1;
    wait_done0("r105", n, 1'b0);

    // Request during SEND is dropped for exactly one cycle.
    request0(9'd123, 1'b0, 1, n);
    wait_txclk0("drop");
    @(posedge clk); #1; ifc0.result = 9'd5; ifc0.result_ready = 1'b1;
    @(posedge clk); #1; ifc0.result_ready = 1'b0;
    @(negedge clk); chk("drop_pulse", {31'd0, ifc0.drop}, 32'd1);
    @(negedge clk); chk("drop_clear", {31'd0, ifc0.drop}, 32'd0);
    wait_done0("rdrop", n, 1'b1);

    // No-terminator variant.
    @(posedge clk); #1;
    ifc1.result = 9'd42; ifc1.result_ready = 1'b1;
    push_exp(9'd42, 1'b0, 1'b0, 1'b1, n);
    @(posedge clk); #1; ifc1.result_ready = 1'b0;
    begin
      int i = 0;
      while (ifc1.busy && i < 100) begin @(negedge clk); i++; end
      chk("nonl_done", {31'd0, ifc1.busy}, 32'd0);
      chk("nonl_queue_empty", exp1_q.size(), 32'd0);
      chk("nonl_len", n, 32'd2);
    end

    // Reset mid-frame abandons it; a later request sends a clean frame.
    request0(9'd123, 1'b0, 1, n);
    wait_txclk0("rst");
    @(posedge clk); #1; nrst = 1'b0;
    #1;
    chk("midrst_txclk",  {31'd0, ifc0.txclk}, 32'd0);
    chk("midrst_busy",   {31'd0, ifc0.busy}, 32'd0);
    chk("midrst_txdata", {24'd0, ifc0.txdata}, 32'h00);
    exp0_q.delete();
    @(posedge clk); #1; nrst = 1'b1;
    request0(9'd123, 1'b0, 1, n);
    wait_done0("rpost", n, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Transmit-side companion to the calculator's keypad/display path.
- When the calculator signals a finished result, this block converts the 9-bit two's-complement value to ASCII decimal and streams it byte-by-byte onto the top-level UART transmit port (txdata/txclk/txready).
- Frame format: optional '-', 1-3 digits, then optional CR LF. An overflowed result is sent as "ERR".

Parameters:
- NEWLINE_EN, 1, when 1 every frame ends with 0x0D 0x0A; when 0 no terminator is sent.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- result  input  9  signed two's-complement value, sampled only when result_ready=1
- o_flag  input  1  overflow flag, sampled together with result
- result_ready  input  1  one-cycle request to send result
- txready  input  1  UART can accept a byte this cycle
- txdata  output  8  byte being offered to UART
- txclk  output  1  byte-valid strobe; a byte transfers on an edge where txclk=1 and txready=1
- busy  output  1  high from the accepted request until the last byte transfers
- drop  output  1  one-cycle pulse when result_ready arrives while busy=1

Behaviour:
- Reset: one clock, asynchronous active-low.
  - nrst=0 forces state to IDLE and clears txdata=8'h00, txclk=0, busy=0, drop=0, the byte buffer and the count.
  - Reset mid-frame abandons the frame; no partial bytes follow.
- All outputs are registered.
- IDLE:
  - On result_ready=1, capture result and o_flag and set busy=1 on the next edge.
  - If o_flag=1, go to LOAD with buffer "E","R","R".
  - Otherwise compute mag = |result| (9'h100 gives 256) and neg = result[8], then go to CONV.
- CONV (multi-cycle, one subtract per cycle):
  - While mag >= 100: mag -= 100, hundreds++.
  - Then while mag >= 10: mag -= 10, tens++.
  - Remainder is ones.
  - Worst case: 2 hundreds steps + 9 tens steps + 1 cycle to exit, i.e. ≤12 cycles.
- LOAD (1 cycle): build a 6-entry byte buffer and a length count.
  - '-' (0x2D) first if neg.
  - Hundreds digit only if nonzero.
  - Tens digit if hundreds or tens is nonzero.
  - Ones digit always (zero prints "0").
  - Then 0x0D 0x0A if NEWLINE_EN.
  - Digit byte = 0x30 + value. Maximum length is 6.
- SEND:
  - txdata = buffer[idx], txclk=1.
  - Each edge with txready=1 advances idx and presents the next byte on the following cycle with txclk still 1, giving back-to-back transfers at 1 byte/cycle.
  - While txready=0, txdata and txclk hold unchanged.
  - On transfer of the last byte: txclk=0, busy=0, return to IDLE next edge.
- The first byte appears no earlier than 2 cycles after result_ready. The block never drives txclk=1 outside SEND.
- result_ready while busy=1 (including the cycle busy falls):
  - The request is ignored and drop=1 for one cycle.
  - The in-flight frame is unaffected.
  - A new request is accepted only in IDLE.
- result_ready=1 on consecutive IDLE cycles: the first is accepted and the second drops.
- txready may toggle arbitrarily; no byte is skipped or duplicated.

Test Plan:
- result=9'd123, o_flag=0, txready=1 → txdata sequence 0x31,0x32,0x33,0x0D,0x0A on 5 consecutive txclk=1 cycles; busy falls after the 0x0A transfer.
- result=9'h100 (-256) → 0x2D,0x32,0x35,0x36,0x0D,0x0A. result=9'h1F9 (-7) → 0x2D,0x37,0x0D,0x0A. result=9'd0 → 0x30,0x0D,0x0A. result=9'd105 → 0x31,0x30,0x35,0x0D,0x0A (checks the inner zero).
- o_flag=1 with any result → 0x45,0x52,0x52,0x0D,0x0A. With NEWLINE_EN=0, result=9'd42 → 0x34,0x32 only.
- Backpressure: hold txready=0 for 5 cycles mid-frame → txdata and txclk=1 stable throughout; release → the remaining bytes follow in order with no duplicates.
- Pulse result_ready during SEND → drop=1 for exactly 1 cycle and the frame completes unchanged. Assert nrst=0 mid-frame → txclk=0, busy=0, txdata=0 immediately; after release, a new request sends a full clean frame.
